// File: rtl/fifo_word_reader.sv
// fifo_word_reader
//   Read-side consumer for the nibble-wide cdc_fifo, living entirely in the
//   FIFO read clock domain. Pops FIFO entries and packs NIBBLES of them into one
//   word, then presents that word on a valid/ready handshake. A flush request
//   emits a partially filled word. A wrapping counter tracks delivered words.
//
// Ports
//   clock          read-domain clock, rising-edge active
//   reset          asynchronous, active-high reset
//   fifo_empty     FIFO empty flag
//   fifo_read_data FIFO head entry (first-word fall-through)
//   fifo_pop       combinational pop strobe to the FIFO
//   out_data       packed word (registered)
//   out_valid      word available (registered state decode)
//   out_ready      downstream accept
//   out_partial    word was produced by flush with fewer than NIBBLES entries
//   out_nibbles    number of valid entries in out_data
//   flush          single-cycle request to emit the partial accumulator
//   word_count     completed handshakes, wraps modulo 2^COUNT_WIDTH
module fifo_word_reader #(
    parameter  int DATA_WIDTH  = 4,
    parameter  int NIBBLES     = 2,
    parameter  int LOW_FIRST   = 1,
    parameter  int COUNT_WIDTH = 16,
    localparam int WORD_WIDTH  = DATA_WIDTH * NIBBLES,
    localparam int NIB_W       = $clog2(NIBBLES + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   fifo_empty,
    input  logic [DATA_WIDTH-1:0]  fifo_read_data,
    output logic                   fifo_pop,
    output logic [WORD_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_partial,
    output logic [NIB_W-1:0]       out_nibbles,
    input  logic                   flush,
    output logic [COUNT_WIDTH-1:0] word_count
);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t                 state_r,   state_nxt_s;
    logic [NIB_W-1:0]       index_r,   index_nxt_s;
    logic [WORD_WIDTH-1:0]  acc_r,     acc_nxt_s;
    logic [WORD_WIDTH-1:0]  data_r,    data_nxt_s;
    logic                   partial_r, partial_nxt_s;
    logic [NIB_W-1:0]       nibbles_r, nibbles_nxt_s;
    logic [COUNT_WIDTH-1:0] count_r,   count_nxt_s;

    logic                   handshake_s;
    logic                   pop_s;
    logic [NIB_W-1:0]       fill_s;
    logic [WORD_WIDTH-1:0]  acc_pop_s;

    // Writes one entry into the slot selected by the fill index; slot order
    // follows LOW_FIRST (index 0 lands in the LS slot when LOW_FIRST=1).
    function automatic logic [WORD_WIDTH-1:0] insert_entry(
        input logic [WORD_WIDTH-1:0] acc,
        input logic [NIB_W-1:0]      idx,
        input logic [DATA_WIDTH-1:0] entry
    );
        logic [WORD_WIDTH-1:0] result;
        int                    slot;
        result = acc;
        slot   = (LOW_FIRST != 0) ? int'(idx) : (NIBBLES - 1 - int'(idx));
        for (int s = 0; s < NIBBLES; s++) begin
            result[s*DATA_WIDTH +: DATA_WIDTH] =
                (s == slot) ? entry : result[s*DATA_WIDTH +: DATA_WIDTH];
        end
        return result;
    endfunction

    // Pop decision and next-state / next-output computation.
    always_comb begin
        handshake_s   = (state_r == HOLD) && out_ready;
        pop_s         = !reset && !fifo_empty && ((state_r == COLLECT) || handshake_s);
        state_nxt_s   = state_r;
        index_nxt_s   = index_r;
        acc_nxt_s     = acc_r;
        data_nxt_s    = data_r;
        partial_nxt_s = partial_r;
        nibbles_nxt_s = nibbles_r;
        count_nxt_s   = count_r;
        // In HOLD the accumulator is already clear with index 0, so the same
        // insert path serves the pop that rides along with a handshake.
        fill_s        = index_r + NIB_W'(pop_s);
        acc_pop_s     = pop_s ? insert_entry(acc_r, index_r, fifo_read_data) : acc_r;

        case (state_r)
            COLLECT: begin
                if (fill_s == NIB_W'(NIBBLES)) begin
                    state_nxt_s   = HOLD;
                    data_nxt_s    = acc_pop_s;
                    partial_nxt_s = 1'b0;
                    nibbles_nxt_s = NIB_W'(NIBBLES);
                    index_nxt_s   = {NIB_W{1'b0}};
                    acc_nxt_s     = {WORD_WIDTH{1'b0}};
                end else if (flush && (fill_s != {NIB_W{1'b0}})) begin
                    state_nxt_s   = HOLD;
                    data_nxt_s    = acc_pop_s;
                    partial_nxt_s = 1'b1;
                    nibbles_nxt_s = fill_s;
                    index_nxt_s   = {NIB_W{1'b0}};
                    acc_nxt_s     = {WORD_WIDTH{1'b0}};
                end else begin
                    acc_nxt_s     = acc_pop_s;
                    index_nxt_s   = fill_s;
                end
            end
            HOLD: begin
                if (handshake_s) begin
                    state_nxt_s = COLLECT;
                    count_nxt_s = count_r + COUNT_WIDTH'(1'b1);
                    acc_nxt_s   = acc_pop_s;
                    index_nxt_s = fill_s;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = COLLECT;
                index_nxt_s = {NIB_W{1'b0}};
                acc_nxt_s   = {WORD_WIDTH{1'b0}};
            end
        endcase
    end

    // State, accumulator and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= COLLECT;
            index_r   <= {NIB_W{1'b0}};
            acc_r     <= {WORD_WIDTH{1'b0}};
            data_r    <= {WORD_WIDTH{1'b0}};
            partial_r <= 1'b0;
            nibbles_r <= {NIB_W{1'b0}};
            count_r   <= {COUNT_WIDTH{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            index_r   <= index_nxt_s;
            acc_r     <= acc_nxt_s;
            data_r    <= data_nxt_s;
            partial_r <= partial_nxt_s;
            nibbles_r <= nibbles_nxt_s;
            count_r   <= count_nxt_s;
        end
    end

    assign fifo_pop    = pop_s;
    assign out_valid   = (state_r == HOLD);
    assign out_data    = data_r;
    assign out_partial = partial_r;
    assign out_nibbles = nibbles_r;
    assign word_count  = count_r;

endmodule

// File: tb/tb_fifo_word_reader.sv
// Self-checking bench for fifo_word_reader: directed scenarios plus random
// traffic compared against a queue-based reference model. A second instance
// with a 3-bit counter exercises counter wrap-around.
module tb_fifo_word_reader;

    localparam int DW = 4;
    localparam int NIB = 2;
    localparam int LOWF = 1;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         fifo_empty = 1'b1;
    logic [3:0]   fifo_read_data = 4'h0;
    logic         fifo_pop;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         out_partial;
    logic [1:0]   out_nibbles;
    logic         flush = 1'b0;
    logic [15:0]  word_count;

    logic         sm_pop, sm_valid, sm_partial;
    logic [7:0]   sm_data;
    logic [1:0]   sm_nibbles;
    logic [2:0]   sm_count;

    fifo_word_reader #(.DATA_WIDTH(DW), .NIBBLES(NIB), .LOW_FIRST(LOWF), .COUNT_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .fifo_empty(fifo_empty), .fifo_read_data(fifo_read_data),
        .fifo_pop(fifo_pop), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_partial(out_partial), .out_nibbles(out_nibbles), .flush(flush), .word_count(word_count));

    fifo_word_reader #(.DATA_WIDTH(DW), .NIBBLES(NIB), .LOW_FIRST(LOWF), .COUNT_WIDTH(3)) dut_small (
        .clock(clock), .reset(reset), .fifo_empty(fifo_empty), .fifo_read_data(fifo_read_data),
        .fifo_pop(sm_pop), .out_data(sm_data), .out_valid(sm_valid), .out_ready(out_ready),
        .out_partial(sm_partial), .out_nibbles(sm_nibbles), .flush(flush), .word_count(sm_count));

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Environment FIFO contents and reference model state.
    logic [3:0]  fifo_q[$];
    int          coll[$];
    bit          m_valid = 1'b0;
    logic [31:0] m_data = 32'h0;
    int          m_n = 0;
    bit          m_part = 1'b0;
    int          m_count = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        fifo_empty     = (fifo_q.size() == 0);
        fifo_read_data = (fifo_q.size() == 0) ? 4'h0 : fifo_q[0];
    endtask

    task automatic model_clear();
        coll.delete();
        m_valid = 1'b0; m_data = 32'h0; m_n = 0; m_part = 1'b0; m_count = 0;
    endtask

    // One clock cycle: drive inputs after the falling edge, check the pop
    // strobe before the rising edge, then check outputs on the next fall.
    task automatic step(input bit rdy, input bit fl);
        bit   e_pop, d_pop;
        int   head;
        logic [31:0] w;
        out_ready = rdy;
        flush     = fl;
        drive_fifo();
        head = (fifo_q.size() == 0) ? 0 : int'(fifo_q[0]);
        #1;
        e_pop = (fifo_q.size() != 0) && (!m_valid || rdy);
        check_eq("fifo_pop", {31'h0, fifo_pop}, {31'h0, e_pop});
        d_pop = fifo_pop;
        @(posedge clock);
        if (d_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (m_valid) begin
            if (rdy) begin
                m_count++;
                m_valid = 1'b0;
                if (e_pop) coll.push_back(head);
            end
        end else begin
            if (e_pop) coll.push_back(head);
            if (coll.size() == NIB || (fl && coll.size() > 0)) begin
                w = 32'h0;
                foreach (coll[i]) w = w | (32'(coll[i]) << (DW * ((LOWF != 0) ? i : NIB - 1 - i)));
                m_valid = 1'b1;
                m_data  = w;
                m_n     = coll.size();
                m_part  = (coll.size() < NIB);
                coll.delete();
            end
        end
        @(negedge clock);
        check_eq("out_valid", {31'h0, out_valid}, {31'h0, m_valid});
        if (m_valid) begin
            check_eq("out_data", {24'h0, out_data}, m_data);
            check_eq("out_partial", {31'h0, out_partial}, {31'h0, m_part});
            check_eq("out_nibbles", {30'h0, out_nibbles}, 32'(m_n));
        end
        check_eq("word_count", {16'h0, word_count}, 32'(m_count) & 32'hFFFF);
        check_eq("wrap_count", {29'h0, sm_count}, 32'(m_count) & 32'h7);
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset();
        drive_fifo();
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        check_eq("rst_valid", {31'h0, out_valid}, 32'h0);
        check_eq("rst_data", {24'h0, out_data}, 32'h0);
        check_eq("rst_partial", {31'h0, out_partial}, 32'h0);
        check_eq("rst_nibbles", {30'h0, out_nibbles}, 32'h0);
        check_eq("rst_count", {16'h0, word_count}, 32'h0);
        check_eq("rst_pop", {31'h0, fifo_pop}, 32'h0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        int p;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Idle with empty FIFO.
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);

        // Single word 0x3, 0xA -> 0xA3.
        fifo_q.push_back(4'h3);
        fifo_q.push_back(4'hA);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check_eq("word_a3", {24'h0, out_data}, 32'hA3);
        step(1'b1, 1'b0);
        check_eq("count_one", {16'h0, word_count}, 32'h1);

        // Back-to-back stream 0x1..0x8.
        for (int i = 1; i <= 8; i++) fifo_q.push_back(4'(i));
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
        check_eq("count_five", {16'h0, word_count}, 32'h5);

        // Backpressure: word held stable, no pop while stalled.
        fifo_q.push_back(4'h9); fifo_q.push_back(4'hB);
        fifo_q.push_back(4'hC); fifo_q.push_back(4'hD);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0);
            check_eq("hold_stable", {24'h0, out_data}, 32'hB9);
        end
        step(1'b1, 1'b0);
        check_eq("handshake_pop", 32'(fifo_q.size()), 32'h1);

        // Reset mid-word; remaining FIFO entry must be left alone.
        do_reset();
        check_eq("fifo_untouched", 32'(fifo_q.size()), 32'h1);
        fifo_q.delete();

        // Flush a partial word, flush when empty, flush during HOLD.
        fifo_q.push_back(4'h5);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check_eq("flush_data", {24'h0, out_data}, 32'h05);
        check_eq("flush_partial", {31'h0, out_partial}, 32'h1);
        check_eq("flush_nibbles", {30'h0, out_nibbles}, 32'h1);
        step(1'b0, 1'b1);
        check_eq("flush_in_hold", {31'h0, out_valid}, 32'h1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check_eq("flush_index0", {31'h0, out_valid}, 32'h0);

        // Reset while a word is held.
        fifo_q.push_back(4'h6); fifo_q.push_back(4'h7);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check_eq("word_76", {24'h0, out_data}, 32'h76);
        do_reset();

        // Random traffic; the 3-bit counter instance wraps many times.
        for (int i = 0; i < 3000; i++) begin
            p = ((i / 400) % 2 == 1) ? 75 : 35;
            if (fifo_q.size() < 16 && $urandom_range(0, 99) < p) fifo_q.push_back(4'($urandom));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
            if (i == 1500) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
